bus_fabric: RTL and testbench

BUS_FABRIC -- requirements
Module: bus_fabric

---
 rtl/bus_fabric.sv | 165 ++++++++++++++++
 tb/tb_bus_fabric.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_fabric.sv
// bus_fabric: single master to N_SLV word-addressed slaves, plus STATUS / FAULT_ADDR registers.
// Define BUS_FABRIC_TIMEOUT_EN to abort slave accesses that exceed TIMEOUT cycles.
module bus_fabric #(
  parameter int          N_SLV     = 4,
  parameter int          SLV_AW    = 10,
  parameter int          TIMEOUT   = 15,
  parameter logic [15:0] STAT_ADDR = 16'hFFF0
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 m_req,
  input  logic [15:0]          m_addr,
  input  logic                 m_we,
  input  logic [15:0]          m_wdata,
  output logic [15:0]          m_rdata,
  output logic                 m_ready,
  output logic [N_SLV-1:0]     s_req,
  output logic [15:0]          s_addr,
  output logic                 s_we,
  output logic [15:0]          s_wdata,
  input  logic [N_SLV*16-1:0]  s_rdata,
  input  logic [N_SLV-1:0]     s_ready,
  output logic                 o_err_int
);

  localparam int          SW         = (N_SLV > 1) ? $clog2(N_SLV) : 1;
  localparam logic [15:0] FAULT_ADDR = STAT_ADDR + 16'd1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state_q, state_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [15:0]   rdata_q, rdata_d;
  logic [15:0]   fault_q, fault_d;
  logic          we_q, we_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [2:0]    status_q, status_d;
  logic [2:0]    statusSet, statusClr;
  logic [15:0]   slotIdx;
  logic          isStat, isUnmapped, selReady, timeoutHit;
  logic [15:0]   selRdata;

  // The register window overrides slot decode, so it is excluded from the unmapped test.
  assign slotIdx    = 16'(m_addr >> SLV_AW);
  assign isStat     = (m_addr == STAT_ADDR) || (m_addr == FAULT_ADDR);
  assign isUnmapped = !isStat && (slotIdx >= 16'(N_SLV));

  always_comb begin
    selReady = 1'b0;
    selRdata = 16'h0000;
    for (int k = 0; k < N_SLV; k++) begin
      if (sel_q == SW'(k)) begin
        selReady = s_ready[k];
        selRdata = s_rdata[16*k +: 16];
      end
    end
  end

`ifdef BUS_FABRIC_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;

  assign timeoutHit = (state_q == ACCESS) && !selReady && (cnt_q == 8'(TIMEOUT - 1));
  assign cnt_d      = (state_q == ACCESS) ? cnt_q + 8'd1 : 8'd0;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) cnt_q <= 8'd0;
    else         cnt_q <= cnt_d;
  end
`else
  // A legal TIMEOUT is never 0, so ACCESS waits for s_ready indefinitely.
  assign timeoutHit = (TIMEOUT == 0);
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (m_req) state_d = (isStat || isUnmapped) ? RESP : ACCESS;
      ACCESS:  if (selReady || timeoutHit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int k = 0; k < N_SLV; k++) begin
      s_req[k] = (state_q == ACCESS) && (sel_q == SW'(k));
    end
    m_ready = (state_q == RESP);
    m_rdata = (state_q == RESP) ? rdata_q : 16'h0000;
  end

  assign s_addr    = addr_q;
  assign s_we      = we_q;
  assign s_wdata   = wdata_q;
  assign o_err_int = |status_q[1:0];

  // A newly raised error beats a W1C clear of the same bit; overrun flags errors that pile up.
  always_comb begin
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    sel_d     = sel_q;
    rdata_d   = rdata_q;
    fault_d   = fault_q;
    statusSet = 3'b000;
    statusClr = 3'b000;
    case (state_q)
      IDLE: begin
        if (m_req) begin
          addr_d  = m_addr;
          we_d    = m_we;
          wdata_d = m_wdata;
          sel_d   = slotIdx[SW-1:0];
          rdata_d = 16'h0000;
          if (isStat) begin
            if (!m_we)                    rdata_d   = (m_addr == STAT_ADDR) ? {13'd0, status_q} : fault_q;
            else if (m_addr == STAT_ADDR) statusClr = m_wdata[2:0];
          end else if (isUnmapped) begin
            statusSet[1] = 1'b1;
            fault_d      = m_addr;
          end
        end
      end
      ACCESS: begin
        if (selReady) begin
          rdata_d = selRdata;
        end else if (timeoutHit) begin
          statusSet[0] = 1'b1;
          fault_d      = addr_q;
          rdata_d      = 16'h0000;
        end
      end
      default: ;
    endcase
    if ((|statusSet) && (|status_q[1:0])) statusSet[2] = 1'b1;
    status_d = (status_q & ~statusClr) | statusSet;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      addr_q   <= 16'h0000;
      we_q     <= 1'b0;
      wdata_q  <= 16'h0000;
      sel_q    <= '0;
      rdata_q  <= 16'h0000;
      fault_q  <= 16'h0000;
      status_q <= 3'b000;
    end else begin
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      sel_q    <= sel_d;
      rdata_q  <= rdata_d;
      fault_q  <= fault_d;
      status_q <= status_d;
    end
  end

endmodule

// File: tb/tb_bus_fabric.sv
// tb_bus_fabric: self-checking bench for bus_fabric (N_SLV=4, SLV_AW=10, TIMEOUT=15, STAT_ADDR=FFF0).
// Slaves are modelled per slot with a programmable ready delay; a transaction-level model tracks STATUS.
module tb_bus_fabric;

  localparam int N   = 4;
  localparam int TMO = 15;
  localparam int NT  = 23;

  logic            i_clk = 1'b0;
  logic            i_reset;
  logic            m_req;
  logic [15:0]     m_addr;
  logic            m_we;
  logic [15:0]     m_wdata;
  logic [15:0]     m_rdata;
  logic            m_ready;
  logic [N-1:0]    s_req;
  logic [15:0]     s_addr;
  logic            s_we;
  logic [15:0]     s_wdata;
  logic [N*16-1:0] s_rdata;
  logic [N-1:0]    s_ready;
  logic            o_err_int;

  bus_fabric #(.N_SLV(N), .SLV_AW(10), .TIMEOUT(TMO), .STAT_ADDR(16'hFFF0)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .m_req(m_req), .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready),
    .s_req(s_req), .s_addr(s_addr), .s_we(s_we), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ready(s_ready),
    .o_err_int(o_err_int)
  );

  always #5 i_clk = ~i_clk;

  // Slave k answers once its request has been held for slvDelay[k] cycles; idle slaves drive noise.
  int           slvDelay[N];
  logic [15:0]  slvData[N];
  logic [N-1:0] noise;
  int           reqCycles = 0;

  always @(posedge i_clk) reqCycles <= (|s_req) ? reqCycles + 1 : 0;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      s_ready[k]          = s_req[k] ? (reqCycles >= slvDelay[k]) : noise[k];
      s_rdata[16*k +: 16] = slvData[k];
    end
  end

  int checks = 0;
  int errors = 0;

  logic [15:0] mStatus = 16'h0000;
  logic [15:0] mFault  = 16'h0000;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
    int          lat;
    int          sreq;
    logic [N-1:0] hot;
    logic [15:0] data;
    logic        err;
  } vec_t;

  vec_t tab[NT];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic raiseError(input int bitIdx, input logic [15:0] addr);
    if (mStatus[1:0] != 2'b00) mStatus[2] = 1'b1;
    mStatus[bitIdx] = 1'b1;
    mFault = addr;
  endtask

  // Transaction-level model: latency, slave-request cycles, selected slot and read data.
  task automatic modelTxn(input logic [15:0] addr, input logic we, input logic [15:0] wdata,
                          output int lat, output int sreqN, output logic [N-1:0] hot,
                          output logic [15:0] data);
    int slot;
    slot  = int'(addr >> 10);
    hot   = '0;
    sreqN = 0;
    data  = 16'h0000;
    lat   = 1;
    if (addr == 16'hFFF0 || addr == 16'hFFF1) begin
      if (!we)                    data = (addr == 16'hFFF0) ? mStatus : mFault;
      else if (addr == 16'hFFF0)  mStatus[2:0] = mStatus[2:0] & ~wdata[2:0];
    end else if (slot >= N) begin
      raiseError(1, addr);
    end else begin
      hot[slot] = 1'b1;
      sreqN     = slvDelay[slot] + 1;
      lat       = sreqN + 1;
      data      = slvData[slot];
`ifdef BUS_FABRIC_TIMEOUT_EN
      if (slvDelay[slot] >= TMO) begin
        sreqN = TMO;
        lat   = TMO + 1;
        data  = 16'h0000;
        raiseError(0, addr);
      end
`endif
    end
  endtask

  task automatic syncModel(input logic [15:0] addr, input logic we, input logic [15:0] wdata);
    int lat, sreqN;
    logic [N-1:0] hot;
    logic [15:0] data;
    modelTxn(addr, we, wdata, lat, sreqN, hot, data);
  endtask

  task automatic applyStimulus(input string tag, input logic [15:0] addr, input logic we,
                               input logic [15:0] wdata, input int expLat, input int expSreq,
                               input logic [N-1:0] expHot, input logic [15:0] expData,
                               input logic expErr);
    int lat, sreqN;
    logic [N-1:0] hotSeen;
    logic [15:0] rd, sAddr, sWd;
    logic sWe, done, idleBad;
    lat = 0; sreqN = 0; hotSeen = '0; rd = 16'h0; sAddr = 16'h0; sWd = 16'h0;
    sWe = 1'b0; done = 1'b0; idleBad = 1'b0;
    @(negedge i_clk);
    m_req = 1'b1; m_addr = addr; m_we = we; m_wdata = wdata;
    @(posedge i_clk);
    #1;
    m_req = 1'b0; m_addr = 16'($urandom); m_we = 1'($urandom); m_wdata = 16'($urandom);
    for (int n = 1; n <= 400 && !done; n++) begin
      @(negedge i_clk);
      if (s_req != '0) begin
        sreqN++;
        hotSeen = hotSeen | s_req;
        sAddr = s_addr; sWd = s_wdata; sWe = s_we;
      end
      if (m_ready) begin
        done = 1'b1; lat = n; rd = m_rdata;
      end else if (m_rdata !== 16'h0000) begin
        idleBad = 1'b1;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("[TB] FAIL %s completion: got no m_ready expected m_ready within 400 cycles", tag);
      return;
    end
    checkOutput({tag, " latency"}, lat, expLat);
    checkOutput({tag, " s_req cycles"}, sreqN, expSreq);
    checkOutput({tag, " s_req one-hot"}, hotSeen, expHot);
    checkOutput({tag, " m_rdata zero while idle"}, idleBad, 1'b0);
    if (expSreq > 0) begin
      checkOutput({tag, " s_addr"}, sAddr, addr);
      checkOutput({tag, " s_we"}, sWe, we);
      if (we) checkOutput({tag, " s_wdata"}, sWd, wdata);
    end
    if (!we) checkOutput({tag, " m_rdata"}, rd, expData);
    @(negedge i_clk);
    checkOutput({tag, " m_ready single pulse"}, m_ready, 1'b0);
    checkOutput({tag, " o_err_int"}, o_err_int, expErr);
  endtask

  task automatic modelRun(input string tag, input logic [15:0] addr, input logic we,
                          input logic [15:0] wdata);
    int lat, sreqN;
    logic [N-1:0] hot;
    logic [15:0] data;
    modelTxn(addr, we, wdata, lat, sreqN, hot, data);
    applyStimulus(tag, addr, we, wdata, lat, sreqN, hot, data, |mStatus[1:0]);
  endtask

  initial begin
    logic bad, seen;
    logic [15:0] rd;
    int kind;
    logic [15:0] a, d;
    logic w;

    tab[0]  = '{16'h0005, 1'b0, 16'h0000, 2, 1, 4'b0001, 16'hA5A5, 1'b0};
    tab[1]  = '{16'h0812, 1'b1, 16'h1234, 4, 3, 4'b0100, 16'h0000, 1'b0};
    tab[2]  = '{16'h0410, 1'b0, 16'h0000, 3, 2, 4'b0010, 16'h5A5A, 1'b0};
    tab[3]  = '{16'h0FFF, 1'b0, 16'h0000, 2, 1, 4'b1000, 16'h0F0F, 1'b0};
    tab[4]  = '{16'hFFF0, 1'b0, 16'h0000, 1, 0, 4'b0000, 16'h0000, 1'b0};
    tab[5]  = '{16'h1000, 1'b0, 16'h0000, 1, 0, 4'b0000, 16'h0000, 1'b1};
    tab[6]  = '{16'hFFF1, 1'b0, 16'h0000, 1, 0, 4'b0000, 16'h1000, 1'b1};
    tab[7]  = '{16'hFFF0, 1'b0, 16'h0000, 1, 0, 4'b0000, 16'h0002, 1'b1};
    tab[8]  = '{16'hFFF1, 1'b1, 16'hFFFF, 1, 0, 4'b0000, 16'h0000, 1'b1};
    tab[9]  = '{16'hFFF1, 1'b0, 16'h0000, 1, 0, 4'b0000, 16'h1000, 1'b1};
    tab[10] = '{16'hFFF0, 1'b1, 16'h0002, 1, 0, 4'b0000, 16'h0000, 1'b0};
    tab[11] = '{16'hFFF0, 1'b0, 16'h0000, 1, 0, 4'b0000, 16'h0000, 1'b0};
    tab[12] = '{16'h2000, 1'b1, 16'hBEEF, 1, 0, 4'b0000, 16'h0000, 1'b1};
    tab[13] = '{16'hC000, 1'b0, 16'h0000, 1, 0, 4'b0000, 16'h0000, 1'b1};
    tab[14] = '{16'hFFF0, 1'b0, 16'h0000, 1, 0, 4'b0000, 16'h0006, 1'b1};
    tab[15] = '{16'hFFF1, 1'b0, 16'h0000, 1, 0, 4'b0000, 16'hC000, 1'b1};
    tab[16] = '{16'hFFF0, 1'b1, 16'h0004, 1, 0, 4'b0000, 16'h0000, 1'b1};
    tab[17] = '{16'hFFF0, 1'b0, 16'h0000, 1, 0, 4'b0000, 16'h0002, 1'b1};
    tab[18] = '{16'hFFF0, 1'b1, 16'h0007, 1, 0, 4'b0000, 16'h0000, 1'b0};
    tab[19] = '{16'hFFF0, 1'b0, 16'h0000, 1, 0, 4'b0000, 16'h0000, 1'b0};
    tab[20] = '{16'hFFF2, 1'b0, 16'h0000, 1, 0, 4'b0000, 16'h0000, 1'b1};
    tab[21] = '{16'hFFF1, 1'b0, 16'h0000, 1, 0, 4'b0000, 16'hFFF2, 1'b1};
    tab[22] = '{16'hFFF0, 1'b1, 16'h0002, 1, 0, 4'b0000, 16'h0000, 1'b0};

    slvDelay[0] = 0; slvDelay[1] = 1; slvDelay[2] = 2; slvDelay[3] = 0;
    slvData[0] = 16'hA5A5; slvData[1] = 16'h5A5A; slvData[2] = 16'hC3C3; slvData[3] = 16'h0F0F;
    noise = '0;
    i_reset = 1'b1; m_req = 1'b0; m_addr = 16'h0000; m_we = 1'b0; m_wdata = 16'h0000;

    #12;
    checkOutput("reset s_req", s_req, 4'b0000);
    checkOutput("reset m_ready", m_ready, 1'b0);
    checkOutput("reset m_rdata", m_rdata, 16'h0000);
    checkOutput("reset o_err_int", o_err_int, 1'b0);
    @(negedge i_clk);
    i_reset = 1'b0;

    for (int i = 0; i < NT; i++) begin
      noise = N'($urandom);
      syncModel(tab[i].addr, tab[i].we, tab[i].wdata);
      applyStimulus($sformatf("vec%0d", i), tab[i].addr, tab[i].we, tab[i].wdata, tab[i].lat,
                    tab[i].sreq, tab[i].hot, tab[i].data, tab[i].err);
    end

    modelRun("clear before wait", 16'hFFF0, 1'b1, 16'h0007);
    slvDelay[1] = 255;
`ifdef BUS_FABRIC_TIMEOUT_EN
    syncModel(16'h0400, 1'b0, 16'h0000);
    applyStimulus("timeout slot1", 16'h0400, 1'b0, 16'h0000, TMO + 1, TMO, 4'b0010, 16'h0000, 1'b1);
    syncModel(16'hFFF0, 1'b0, 16'h0000);
    applyStimulus("status after timeout", 16'hFFF0, 1'b0, 16'h0000, 1, 0, 4'b0000, 16'h0001, 1'b1);
    syncModel(16'h3000, 1'b0, 16'h0000);
    applyStimulus("unmapped after timeout", 16'h3000, 1'b0, 16'h0000, 1, 0, 4'b0000, 16'h0000, 1'b1);
    syncModel(16'hFFF0, 1'b0, 16'h0000);
    applyStimulus("status overrun", 16'hFFF0, 1'b0, 16'h0000, 1, 0, 4'b0000, 16'h0007, 1'b1);
    modelRun("fault after overrun", 16'hFFF1, 1'b0, 16'h0000);
`else
    @(negedge i_clk);
    m_req = 1'b1; m_addr = 16'h0420; m_we = 1'b0;
    @(posedge i_clk);
    #1 m_req = 1'b0;
    bad = 1'b0;
    repeat (40) begin
      @(negedge i_clk);
      if (s_req !== 4'b0010 || m_ready !== 1'b0) bad = 1'b1;
    end
    checkOutput("indefinite wait holds s_req", bad, 1'b0);
    slvData[1] = 16'h6C6C;
    slvDelay[1] = 0;
    seen = 1'b0; rd = 16'h0000;
    for (int n = 0; n < 5 && !seen; n++) begin
      @(negedge i_clk);
      if (m_ready) begin seen = 1'b1; rd = m_rdata; end
    end
    checkOutput("late ready completes", seen, 1'b1);
    checkOutput("late ready data", rd, 16'h6C6C);
    modelRun("status after long wait", 16'hFFF0, 1'b0, 16'h0000);
`endif

    for (int t = 0; t < 150; t++) begin
      for (int k = 0; k < N; k++) begin
        slvData[k]  = 16'($urandom);
        slvDelay[k] = $urandom_range(0, 4);
      end
      noise = N'($urandom);
      kind  = $urandom_range(0, 9);
      w     = 1'($urandom);
      d     = 16'($urandom);
      if (kind <= 5)      a = 16'($urandom_range(0, 16'h0FFF));
      else if (kind <= 7) a = ($urandom_range(0, 1) == 0) ? 16'hFFF0 : 16'hFFF1;
      else                a = 16'($urandom_range(16'h1000, 16'hFFEF));
      modelRun($sformatf("rand%0d", t), a, w, d);
    end

    noise = '0;
    modelRun("error before reset", 16'h8000, 1'b0, 16'h0000);
    slvDelay[0] = 255;
    @(negedge i_clk);
    m_req = 1'b1; m_addr = 16'h0000; m_we = 1'b0;
    @(posedge i_clk);
    #1 m_req = 1'b0;
    repeat (3) @(negedge i_clk);
    checkOutput("s_req before reset", s_req, 4'b0001);
    #2 i_reset = 1'b1;
    #1;
    checkOutput("mid-access reset s_req", s_req, 4'b0000);
    checkOutput("mid-access reset m_ready", m_ready, 1'b0);
    checkOutput("mid-access reset o_err_int", o_err_int, 1'b0);
    mStatus = 16'h0000;
    mFault  = 16'h0000;
    bad = 1'b0;
    repeat (2) begin
      @(negedge i_clk);
      if (m_ready !== 1'b0) bad = 1'b1;
    end
    i_reset = 1'b0;
    @(negedge i_clk);
    if (m_ready !== 1'b0 || s_req !== 4'b0000) bad = 1'b1;
    checkOutput("no m_ready after reset abort", bad, 1'b0);
    slvDelay[0] = 0;
    slvData[0]  = 16'h1357;
    syncModel(16'h0000, 1'b0, 16'h0000);
    applyStimulus("post-reset read", 16'h0000, 1'b0, 16'h0000, 2, 1, 4'b0001, 16'h1357, 1'b0);
    modelRun("post-reset fault addr", 16'hFFF1, 1'b0, 16'h0000);
    modelRun("post-reset status", 16'hFFF0, 1'b0, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
